// File: rtl/perf_monitor.sv
// Run-control FSM (IDLE/RUN/DRAIN/DONE) plus cycle, retired-instruction and generic event counters.
// Counters are read through a registered select port; overflow flags are sticky per counter.
module perf_monitor #(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned N_EVT        = 4,
    parameter int unsigned DRAIN_CYCLES = 20,
    parameter int unsigned SATURATE     = 1,
    localparam int unsigned N_CNT       = N_EVT + 2,
    localparam int unsigned SEL_W       = $clog2(N_EVT + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop_req,
    input  logic             clr,
    input  logic             inst_ret,
    input  logic [N_EVT-1:0] evt_in,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic [N_CNT-1:0] ovf,
    output logic             running,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned      DRN_W      = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_e           state_q, state_d;
    logic [DRN_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0] cnt_q [N_CNT];
    logic [CNT_W-1:0] cnt_d [N_CNT];
    logic [N_CNT-1:0] ovf_q, ovf_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic [N_CNT-1:0] inc;
    logic             clear_cnt;
    logic             active;

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        clear_cnt = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    clear_cnt = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop_req) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - DRN_W'(1);
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    clear_cnt = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clr) begin
            state_d   = ST_IDLE;
            drain_d   = '0;
            clear_cnt = 1'b1;
        end
    end

    // Drain cycles still retire instructions and events, but are not charged as run cycles.
    always_comb begin
        active = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        inc    = '0;
        inc[0] = (state_q == ST_RUN);
        inc[1] = inst_ret && active;
        for (int k = 0; k < int'(N_EVT); k++) begin
            inc[2 + k] = evt_in[k] && active;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(N_CNT); i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            if (clear_cnt) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (inc[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
                    cnt_d[i] = (SATURATE != 0) ? CNT_MAX : '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Read port shows the value held this cycle, not the one being written at the edge.
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < int'(N_CNT); i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_data_d = cnt_q[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            drain_q   <= '0;
            ovf_q     <= '0;
            rd_data_q <= '0;
            // NOTE: the counter array is flop-based and reset explicitly; software reads zero after reset.
            for (int i = 0; i < int'(N_CNT); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
            for (int i = 0; i < int'(N_CNT); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign rd_data = rd_data_q;
    assign ovf     = ovf_q;
    assign running = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done    = (state_q == ST_DONE);

endmodule
